// File: rtl/wb_reg_file.sv
// Writeback stage: WB pipeline register, 32x32 register file with write-once
// commit under stall, and two combinational read ports with WB bypass.

// One read port: zero register, WB bypass, then array lookup.
module wb_rf_rdport (
  input  logic             i_en,
  input  logic [4:0]       i_addr,
  input  logic [31:0][31:0] i_mem,
  input  logic             i_commit,
  input  logic [4:0]       i_wreg,
  input  logic [31:0]      i_wdata,
  output logic [31:0]      o_data,
  output logic             o_hit
);

  logic w_nz;

  assign w_nz = (i_addr != 5'd0);

  // Bypass only when the pending WB entry will actually commit to this address.
  always_comb begin
    o_hit  = i_en && w_nz && i_commit && (i_wreg == i_addr);
    o_data = 32'd0;
    if (i_en && w_nz) o_data = o_hit ? i_wdata : i_mem[i_addr];
  end

endmodule

module wb_reg_file (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ex_valid,
  input  logic        i_ex_reg_write,
  input  logic [4:0]  i_ex_write_reg,
  input  logic [31:0] i_ex_write_data,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic [4:0]  i_rs_addr,
  input  logic [4:0]  i_rt_addr,
  output logic [31:0] o_rs_data,
  output logic [31:0] o_rt_data,
  output logic        o_wb_valid,
  output logic        o_wb_reg_write,
  output logic [4:0]  o_wb_write_reg,
  output logic [31:0] o_wb_write_data,
  output logic        o_fwd_rs_hit,
  output logic        o_fwd_rt_hit
);

  localparam int NUM_RD = 2;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic [4:0]  wreg;
    logic [31:0] data;
  } wb_t;

  wb_t                         r_wb;
  logic [31:1][31:0]           r_mem;
  logic [31:0][31:0]           w_mem;
  logic                        w_commit;
  logic [NUM_RD-1:0][4:0]      w_rd_addr;
  logic [NUM_RD-1:0][31:0]     w_rd_data;
  logic [NUM_RD-1:0]           w_rd_hit;

  // Entry 0 is hardwired zero; only entries 1..31 hold state.
  assign w_mem    = {r_mem, 32'd0};
  assign w_commit = r_wb.valid && r_wb.reg_write && (r_wb.wreg != 5'd0);

  // WB pipeline register: flush beats stall; a stalled entry commits once.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wb <= '0;
    end else if (i_flush) begin
      r_wb <= '0;
    end else if (i_stall) begin
      r_wb.reg_write <= r_wb.reg_write && !w_commit;
    end else begin
      r_wb.valid     <= i_ex_valid;
      r_wb.reg_write <= i_ex_reg_write;
      r_wb.wreg      <= i_ex_write_reg;
      r_wb.data      <= i_ex_write_data;
    end
  end

  // Register array commit, independent of stall/flush this cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem <= '0;
    end else if (w_commit) begin
      r_mem[r_wb.wreg] <= r_wb.data;
    end
  end

  assign w_rd_addr[0] = i_rs_addr;
  assign w_rd_addr[1] = i_rt_addr;

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    wb_rf_rdport u_rd (
      .i_en    (i_rst_n),
      .i_addr  (w_rd_addr[g]),
      .i_mem   (w_mem),
      .i_commit(w_commit),
      .i_wreg  (r_wb.wreg),
      .i_wdata (r_wb.data),
      .o_data  (w_rd_data[g]),
      .o_hit   (w_rd_hit[g])
    );
  end

  assign o_rs_data       = w_rd_data[0];
  assign o_rt_data       = w_rd_data[1];
  assign o_fwd_rs_hit    = w_rd_hit[0];
  assign o_fwd_rt_hit    = w_rd_hit[1];
  assign o_wb_valid      = r_wb.valid;
  assign o_wb_reg_write  = r_wb.reg_write;
  assign o_wb_write_reg  = r_wb.wreg;
  assign o_wb_write_data = r_wb.data;

endmodule

// File: tb/tb_wb_reg_file.sv
// Directed bench for wb_reg_file with a reference model checked every cycle.
module tb_wb_reg_file;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ex_valid = 1'b0, ex_rw = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [4:0]  ex_reg = 5'd0, rs_addr = 5'd0, rt_addr = 5'd0;
  logic [31:0] ex_data = 32'd0;
  logic [31:0] rs_data, rt_data, wb_data;
  logic        wb_valid, wb_rw, rs_hit, rt_hit;
  logic [4:0]  wb_reg;

  int total = 0;
  int bad   = 0;
  bit run   = 1'b0;

  // Reference state: architectural register contents plus the WB entry.
  logic [31:0] m_mem [32];
  logic        m_valid, m_rw;
  logic [4:0]  m_reg;
  logic [31:0] m_data;

  always #5 clk = ~clk;

  wb_reg_file dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ex_valid(ex_valid), .i_ex_reg_write(ex_rw),
    .i_ex_write_reg(ex_reg), .i_ex_write_data(ex_data), .i_stall(stall), .i_flush(flush),
    .i_rs_addr(rs_addr), .i_rt_addr(rt_addr), .o_rs_data(rs_data), .o_rt_data(rt_data),
    .o_wb_valid(wb_valid), .o_wb_reg_write(wb_rw), .o_wb_write_reg(wb_reg),
    .o_wb_write_data(wb_data), .o_fwd_rs_hit(rs_hit), .o_fwd_rt_hit(rt_hit)
  );

  function automatic bit m_pending();
    return m_valid && m_rw && (m_reg != 5'd0);
  endfunction

  function automatic bit m_hit(input logic [4:0] a);
    return rst_n && (a != 5'd0) && m_pending() && (m_reg == a);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (!rst_n || a == 5'd0) return 32'd0;
    if (m_hit(a)) return m_data;
    return m_mem[a];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
    m_valid = 1'b0; m_rw = 1'b0; m_reg = 5'd0; m_data = 32'd0;
  endtask

  // Model of one rising edge, using the inputs held across that edge.
  task automatic m_edge();
    bit c;
    c = m_pending();
    if (c) m_mem[m_reg] = m_data;
    if (flush) begin
      m_valid = 1'b0; m_rw = 1'b0; m_reg = 5'd0; m_data = 32'd0;
    end else if (stall) begin
      if (c) m_rw = 1'b0;
    end else begin
      m_valid = ex_valid; m_rw = ex_rw; m_reg = ex_reg; m_data = ex_data;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst_n) m_edge();
    #1;
  endtask

  task automatic ex(input logic v, input logic rw, input logic [4:0] r, input logic [31:0] d);
    ex_valid = v; ex_rw = rw; ex_reg = r; ex_data = d;
  endtask

  // Every cycle, away from the active edge, outputs must match the model.
  always @(negedge clk) begin
    if (run) begin
      chk("cmp_rs_data", rs_data, m_read(rs_addr));
      chk("cmp_rt_data", rt_data, m_read(rt_addr));
      chk("cmp_rs_hit", {31'd0, rs_hit}, {31'd0, m_hit(rs_addr)});
      chk("cmp_rt_hit", {31'd0, rt_hit}, {31'd0, m_hit(rt_addr)});
      chk("cmp_wb_valid", {31'd0, wb_valid}, {31'd0, m_valid});
      chk("cmp_wb_rw", {31'd0, wb_rw}, {31'd0, m_rw});
      chk("cmp_wb_reg", {27'd0, wb_reg}, {27'd0, m_reg});
      chk("cmp_wb_data", wb_data, m_data);
    end
  end

  initial begin
    m_reset();
    #1 rst_n = 1'b0;
    #1 run = 1'b1;
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_rs_data", rs_data, 32'd0);
    @(negedge clk); @(negedge clk);
    #1 rst_n = 1'b1;
    cyc();

    // Write r5, bypass visible next cycle, array value the cycle after.
    ex(1, 1, 5'd5, 32'hDEADBEEF); rs_addr = 5'd5; rt_addr = 5'd5;
    cyc();
    ex(0, 0, 5'd0, 32'd0);
    #1;
    chk("byp_rs_data", rs_data, 32'hDEADBEEF);
    chk("byp_rs_hit", {31'd0, rs_hit}, 32'd1);
    chk("byp_rt_data", rt_data, 32'hDEADBEEF);
    cyc();
    chk("arr_rs_data", rs_data, 32'hDEADBEEF);
    chk("arr_rs_hit", {31'd0, rs_hit}, 32'd0);

    // Writes to r0 are discarded.
    ex(1, 1, 5'd0, 32'h12345678); rs_addr = 5'd0; rt_addr = 5'd0;
    cyc();
    ex(0, 0, 5'd0, 32'd0);
    #1;
    chk("r0_rs_data", rs_data, 32'd0);
    chk("r0_rt_hit", {31'd0, rt_hit}, 32'd0);
    cyc();
    chk("r0_after", rt_data, 32'd0);

    // Stalled WB entry commits once and then drops reg_write.
    ex(1, 1, 5'd31, 32'h00400008);
    cyc();
    stall = 1'b1; ex(1, 1, 5'd4, 32'h00000BAD);
    #1;
    chk("stl_rw_before", {31'd0, wb_rw}, 32'd1);
    cyc();
    chk("stl_rw_after", {31'd0, wb_rw}, 32'd0);
    chk("stl_reg_held", {27'd0, wb_reg}, 32'd31);
    cyc(); cyc();
    rs_addr = 5'd31; rt_addr = 5'd4;
    #1;
    chk("stl_r31", rs_data, 32'h00400008);
    chk("stl_r31_hit", {31'd0, rs_hit}, 32'd0);
    chk("stl_r4", rt_data, 32'd0);
    stall = 1'b0; ex(0, 0, 5'd0, 32'd0);
    cyc();

    // Flush beats stall: r7 keeps its old value.
    ex(1, 1, 5'd7, 32'h00000077);
    cyc();
    ex(0, 0, 5'd0, 32'd0);
    cyc();
    stall = 1'b1; flush = 1'b1; ex(1, 1, 5'd7, 32'hAAAA5555);
    cyc();
    chk("fl_valid", {31'd0, wb_valid}, 32'd0);
    chk("fl_data", wb_data, 32'd0);
    stall = 1'b0; flush = 1'b0; ex(0, 0, 5'd0, 32'd0);
    cyc();
    rs_addr = 5'd7;
    #1;
    chk("fl_r7", rs_data, 32'h00000077);

    // Reset mid-cycle discards pending write and clears the array.
    ex(1, 1, 5'd1, 32'h11); cyc();
    ex(1, 1, 5'd2, 32'h22); cyc();
    ex(1, 1, 5'd3, 32'h33); cyc();
    ex(1, 1, 5'd2, 32'h99); cyc();
    ex(0, 0, 5'd0, 32'd0);
    rs_addr = 5'd2; rt_addr = 5'd3;
    #1;
    chk("pre_rst_r2_byp", rs_data, 32'h99);
    chk("pre_rst_r3", rt_data, 32'h33);
    rst_n = 1'b0; m_reset();
    #1;
    chk("mid_rst_rs", rs_data, 32'd0);
    chk("mid_rst_rt", rt_data, 32'd0);
    chk("mid_rst_hit", {31'd0, rs_hit}, 32'd0);
    chk("mid_rst_wbv", {31'd0, wb_valid}, 32'd0);
    chk("mid_rst_wbd", wb_data, 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    cyc(); cyc();
    rs_addr = 5'd1; rt_addr = 5'd2;
    #1;
    chk("post_rst_r1", rs_data, 32'd0);
    chk("post_rst_r2", rt_data, 32'd0);
    rs_addr = 5'd3;
    #1;
    chk("post_rst_r3", rs_data, 32'd0);

    // Invalid EX instruction is a bubble even with reg_write set.
    ex(0, 1, 5'd9, 32'hFFFFFFFF); rs_addr = 5'd9;
    cyc();
    ex(0, 0, 5'd0, 32'd0);
    #1;
    chk("bub_r9", rs_data, 32'd0);
    chk("bub_hit", {31'd0, rs_hit}, 32'd0);
    cyc();
    chk("bub_r9_after", rs_data, 32'd0);

    // Back-to-back writes with overlapping reads on both ports.
    ex(1, 1, 5'd10, 32'hCAFE0001); cyc();
    ex(1, 1, 5'd11, 32'hCAFE0002); rs_addr = 5'd10; rt_addr = 5'd11;
    #1;
    chk("b2b_r10_byp", rs_data, 32'hCAFE0001);
    cyc();
    ex(0, 0, 5'd0, 32'd0);
    #1;
    chk("b2b_r10_arr", rs_data, 32'hCAFE0001);
    chk("b2b_r11_byp", rt_data, 32'hCAFE0002);
    cyc(); cyc();

    run = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
